mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Two-master, one-slave arbiter between the CPU's instruction-side and data-side memory ports and the single shared memory/L2 port. It registers the winning request, forwards the slave's response and retry to the granted master only, and holds the grant until the transaction completes. The data side has priority, with a starvation counter that guarantees instruction-fetch progress. It sits directly downstream of the pipeline datapath's imem/dmem interfaces and uses the same stb/cyc/resp/retry handshake.

Parameters:
ADDR_W, 16, address width (lc3b_word)
DATA_W, 128, read/write data width (lc3b_data)
MASK_W, 16, byte-enable width
STARVE_LIMIT, 4, maximum number of consecutive D grants while I is pending before I is forced

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_cyc  in  1  instruction master bus cycle
i_stb  in  1  instruction master strobe
i_addr  in  ADDR_W  instruction address (always a read)
i_rdata  out  DATA_W  read data to instruction master
i_resp  out  1  instruction transaction done
i_retry  out  1  instruction retry
d_cyc  in  1  data master bus cycle
d_stb  in  1  data master strobe
d_we  in  1  data write enable
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  data write data
d_sel  in  MASK_W  data byte enables
d_rdata  out  DATA_W  read data to data master
d_resp  out  1  data transaction done
d_retry  out  1  data retry
m_cyc  out  1  slave bus cycle
m_stb  out  1  slave strobe
m_we  out  1  slave write enable
m_addr  out  ADDR_W  slave address
m_wdata  out  DATA_W  slave write data
m_sel  out  MASK_W  slave byte enables
m_rdata  in  DATA_W  slave read data
m_resp  in  1  slave done
m_retry  in  1  slave retry

Behaviour:
- Reset (asynchronous, active when rst_n=0):
  - state=IDLE, starve_cnt=0.
  - m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel all 0.
  - i_resp, i_retry, d_resp, d_retry all 0.
  - Asserting reset mid-transaction drops m_cyc/m_stb immediately; no response is delivered.
- A request is pending when x_cyc & x_stb.
- States: IDLE, GRANT_I, GRANT_D, BACKOFF.
- IDLE:
  - If D is pending and (I is not pending or starve_cnt < STARVE_LIMIT), go to GRANT_D.
  - Otherwise, if I is pending, go to GRANT_I.
  - On the grant edge, latch the winner's addr, wdata, sel and we into the m_* registers. For I grants: we=0, sel=all ones, wdata=0.
  - Record owner (I or D) in a register.
- Latency: request pending in IDLE at cycle t; m_cyc=m_stb=1 from cycle t+1.
- GRANT_x: m_cyc and m_stb are held, and the m_* fields stay stable until m_resp or m_retry.
- m_resp=1:
  - x_resp=1 in the same cycle; x_rdata=m_rdata combinationally.
  - Non-owner resp and retry stay 0.
  - Next state is IDLE; m_cyc and m_stb are 0 from the next cycle.
  - A back-to-back grant therefore has one idle cycle.
- m_retry=1 (and m_resp=0):
  - x_retry=1 for one cycle.
  - Next state is BACKOFF: m_stb=0, m_cyc stays 1, fields held.
  - After one cycle, return to GRANT_x and re-raise m_stb. The owner is not re-arbitrated.
- m_resp and m_retry in the same cycle: m_resp wins and no retry is forwarded.
- Owner drops x_cyc while in GRANT_x or BACKOFF: abort. Next state is IDLE, m_cyc=m_stb=0 next cycle, and no resp is forwarded.
- i_rdata and d_rdata always carry m_rdata; they are qualified only by x_resp.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while I is pending.
  - Clears on every I grant.
  - Holds when I is not pending.
- Simultaneous new requests while busy are not registered; a master holds its strobe until resp (bus rule).

Decomposition:
- Shared lc3b_types package: reuse lc3b_word, lc3b_data and lc3b_mem_wmask.
- Add to the same package:
  - enum lc3b_arb_state_t {IDLE, GRANT_I, GRANT_D, BACKOFF}
  - enum lc3b_arb_owner_t {OWN_I, OWN_D}
- No sub-module. A single FSM plus a request-capture register block is natural. The existing parameterised register module may be used for the m_* field latches.

Test Plan:
- I only: i_addr=0x0040 pending at cycle 0 → m_stb=1 and m_addr=0x0040 at cycle 1, m_we=0, m_sel=0xFFFF. Slave m_resp with m_rdata=0xA5…A5 at cycle 3 → i_resp=1, i_rdata=0xA5…A5 at cycle 3, d_resp=0, m_cyc=0 at cycle 4.
- Simultaneous: I@0x0100 and D write@0x2000 (d_sel=0x0003) both pending in the same cycle → D granted first (m_we=1, m_addr=0x2000). After d_resp, I is granted two cycles after that response.
- Starvation: I pending while D re-requests continuously → D gets exactly 4 consecutive grants, the 5th grant goes to I, and starve_cnt reads 0 afterwards.
- Retry: D grant, slave m_retry=1 at cycle 2 → d_retry=1 at cycle 2, m_stb=0 and m_cyc=1 at cycle 3, m_stb=1 with the same address at cycle 4. A later m_resp → d_resp=1.
- Abort: owner I drops i_cyc while granted → m_cyc=0 next cycle, i_resp never asserted, and a pending D is granted the following cycle.
- Reset mid-transfer: rst_n=0 during GRANT_D → m_cyc, m_stb and all resp/retry outputs are 0 asynchronously. After release, a fresh request is granted normally with starve_cnt=0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: bus word/data/mask widths and the
// state/owner encodings of the instruction/data memory-port arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;
    typedef logic [15:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        BACKOFF
    } lc3b_arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } lc3b_arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-master (I-fetch, data) to one-slave memory port arbiter. Data side has
// priority; a saturating starvation counter forces an I grant after a run of D grants.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 128,
    parameter int MASK_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    output logic              i_retry,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_sel,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              d_retry,
    output logic              m_cyc,
    output logic              m_stb,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [MASK_W-1:0] m_sel,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_resp,
    input  logic              m_retry
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    lc3b_arb_state_t   state_q, state_d;
    lc3b_arb_owner_t   owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              m_cyc_q, m_cyc_d;
    logic              m_stb_q, m_stb_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [MASK_W-1:0] m_sel_q, m_sel_d;

    logic i_pend, d_pend, own_cyc, serving;

    assign i_pend  = i_cyc & i_stb;
    assign d_pend  = d_cyc & d_stb;
    assign own_cyc = (owner_q == OWN_D) ? d_cyc : i_cyc;
    // Slave handshakes are only meaningful while the strobe is up and the owner is still on the bus.
    assign serving = ((state_q == GRANT_I) || (state_q == GRANT_D)) && own_cyc;

    assign i_resp  = serving && (owner_q == OWN_I) && m_resp;
    assign i_retry = serving && (owner_q == OWN_I) && m_retry && !m_resp;
    assign d_resp  = serving && (owner_q == OWN_D) && m_resp;
    assign d_retry = serving && (owner_q == OWN_D) && m_retry && !m_resp;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_sel_d      = m_sel_q;
        case (state_q)
            IDLE: begin
                if (d_pend && (!i_pend || (starve_cnt_q < LIMIT_C))) begin
                    state_d   = GRANT_D;
                    owner_d   = OWN_D;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_sel_d   = d_sel;
                    if (i_pend && (starve_cnt_q != LIMIT_C)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (i_pend) begin
                    state_d      = GRANT_I;
                    owner_d      = OWN_I;
                    m_we_d       = 1'b0;
                    m_addr_d     = i_addr;
                    m_wdata_d    = '0;
                    m_sel_d      = '1;
                    starve_cnt_d = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!own_cyc || m_resp) begin
                    state_d = IDLE;
                end else if (m_retry) begin
                    state_d = BACKOFF;
                end
            end
            BACKOFF: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end else if (owner_q == OWN_D) begin
                    state_d = GRANT_D;
                end else begin
                    state_d = GRANT_I;
                end
            end
            default: state_d = IDLE;
        endcase
        m_cyc_d = (state_d != IDLE);
        m_stb_d = (state_d == GRANT_I) || (state_d == GRANT_D);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            starve_cnt_q <= '0;
            m_cyc_q      <= 1'b0;
            m_stb_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_sel_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            m_cyc_q      <= m_cyc_d;
            m_stb_q      <= m_stb_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_sel_q      <= m_sel_d;
        end
    end

    assign m_cyc   = m_cyc_q;
    assign m_stb   = m_stb_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_sel   = m_sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, starvation and
// reset sequences, then randomized masters/slave against a transaction-level model.
module tb_mem_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_cyc, i_stb;
    logic [15:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_resp, i_retry;
    logic         d_cyc, d_stb, d_we;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic [15:0]  d_sel;
    logic [127:0] d_rdata;
    logic         d_resp, d_retry;
    logic         m_cyc, m_stb, m_we;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    logic [15:0]  m_sel;
    logic [127:0] m_rdata;
    logic         m_resp, m_retry;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(128), .MASK_W(16), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_resp(i_resp), .i_retry(i_retry),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_sel(d_sel), .d_rdata(d_rdata),
        .d_resp(d_resp), .d_retry(d_retry),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_sel(m_sel), .m_rdata(m_rdata),
        .m_resp(m_resp), .m_retry(m_retry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ic;
        logic [15:0] ia;
        logic        dc;
        logic        dwe;
        logic [15:0] da;
        logic [15:0] ds;
        logic        rs;
        logic        rt;
        logic        ec;
        logic        es;
        logic        ew;
        logic [15:0] ea;
        logic [15:0] esl;
        logic [3:0]  er;   // {i_resp, i_retry, d_resp, d_retry}
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(logic ic, logic [15:0] ia, logic dc, logic dwe,
                                logic [15:0] da, logic [15:0] ds, logic rs, logic rt,
                                logic ec, logic es, logic ew, logic [15:0] ea,
                                logic [15:0] esl, logic [3:0] er);
        vec_t v;
        v.ic = ic; v.ia = ia; v.dc = dc; v.dwe = dwe; v.da = da; v.ds = ds;
        v.rs = rs; v.rt = rt; v.ec = ec; v.es = es; v.ew = ew; v.ea = ea;
        v.esl = esl; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cyc = 0; i_stb = 0; i_addr = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_sel = '0;
        m_resp = 0; m_retry = 0;
    endtask

    // Hold I (0x0500) and D (0x0600) pending, slave answers every strobe at once.
    // pat[k]=1 means the k-th grant must go to D.
    task automatic run_starve(input int ngr, input logic [15:0] pat);
        int got = 0;
        int cyc = 0;
        i_cyc = 1; i_stb = 1; i_addr = 16'h0500;
        d_cyc = 1; d_stb = 1; d_we = 0; d_addr = 16'h0600; d_sel = 16'hFFFF;
        while (got < ngr && cyc < 300) begin
            next_cycle();
            cyc++;
            m_resp = m_stb;
            #3;
            if (m_stb) begin
                chk($sformatf("starve_grant%0d", got), 128'(m_addr == 16'h0600), 128'(pat[got]));
                got++;
            end
        end
        if (got < ngr) chk("starve_timeout", 128'(got), 128'(ngr));
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    // Random-phase model state
    logic        busy, bo, own_d;
    int          d_streak;
    logic        cap_we;
    logic [15:0] cap_addr, cap_sel;
    logic [127:0] cap_wdata;
    logic        i_act, d_act;

    initial begin
        logic [127:0] rd_pat;
        int w;
        idle_inputs();
        rd_pat = {16{8'hA5}};
        m_rdata = rd_pat;
        rst_n = 0;
        #2;
        chk("rst_m_cyc", 128'(m_cyc), 128'(0));
        chk("rst_m_stb", 128'(m_stb), 128'(0));
        chk("rst_m_we", 128'(m_we), 128'(0));
        chk("rst_m_addr", 128'(m_addr), 128'(0));
        chk("rst_m_sel", 128'(m_sel), 128'(0));
        chk("rst_m_wdata", m_wdata, 128'(0));
        chk("rst_resps", 128'({i_resp, i_retry, d_resp, d_retry}), 128'(0));
        next_cycle();
        next_cycle();
        rst_n = 1;

        //   ic  ia        dc dwe da        ds        rs rt | ec es ew ea        esl       er
        tbl[0]  = mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[1]  = mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 0,  1, 1, 0, 16'h0040, 16'hFFFF, 4'b0000);
        tbl[2]  = mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 0,  1, 1, 0, 16'h0040, 16'hFFFF, 4'b0000);
        tbl[3]  = mk(1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 1, 0,  1, 1, 0, 16'h0040, 16'hFFFF, 4'b1000);
        tbl[4]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[5]  = mk(1, 16'h0100, 1, 1, 16'h2000, 16'h0003, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[6]  = mk(1, 16'h0100, 1, 1, 16'h2000, 16'h0003, 0, 0,  1, 1, 1, 16'h2000, 16'h0003, 4'b0000);
        tbl[7]  = mk(1, 16'h0100, 1, 1, 16'h2000, 16'h0003, 1, 0,  1, 1, 1, 16'h2000, 16'h0003, 4'b0010);
        tbl[8]  = mk(1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[9]  = mk(1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 0, 0,  1, 1, 0, 16'h0100, 16'hFFFF, 4'b0000);
        tbl[10] = mk(1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 1, 0,  1, 1, 0, 16'h0100, 16'hFFFF, 4'b1000);
        tbl[11] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[12] = mk(0, 16'h0000, 1, 0, 16'h3000, 16'hFFFF, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[13] = mk(0, 16'h0000, 1, 0, 16'h3000, 16'hFFFF, 0, 0,  1, 1, 0, 16'h3000, 16'hFFFF, 4'b0000);
        tbl[14] = mk(0, 16'h0000, 1, 0, 16'h3000, 16'hFFFF, 0, 1,  1, 1, 0, 16'h3000, 16'hFFFF, 4'b0001);
        tbl[15] = mk(0, 16'h0000, 1, 0, 16'h3000, 16'hFFFF, 0, 0,  1, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[16] = mk(0, 16'h0000, 1, 0, 16'h3000, 16'hFFFF, 0, 0,  1, 1, 0, 16'h3000, 16'hFFFF, 4'b0000);
        tbl[17] = mk(0, 16'h0000, 1, 0, 16'h3000, 16'hFFFF, 1, 1,  1, 1, 0, 16'h3000, 16'hFFFF, 4'b0010);
        tbl[18] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[19] = mk(1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[20] = mk(1, 16'h0200, 1, 0, 16'h4000, 16'h00F0, 0, 0,  1, 1, 0, 16'h0200, 16'hFFFF, 4'b0000);
        tbl[21] = mk(0, 16'h0000, 1, 0, 16'h4000, 16'h00F0, 0, 0,  1, 1, 0, 16'h0200, 16'hFFFF, 4'b0000);
        tbl[22] = mk(0, 16'h0000, 1, 0, 16'h4000, 16'h00F0, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);
        tbl[23] = mk(0, 16'h0000, 1, 0, 16'h4000, 16'h00F0, 0, 0,  1, 1, 0, 16'h4000, 16'h00F0, 4'b0000);
        tbl[24] = mk(0, 16'h0000, 1, 0, 16'h4000, 16'h00F0, 1, 0,  1, 1, 0, 16'h4000, 16'h00F0, 4'b0010);
        tbl[25] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 4'b0000);

        for (int r = 0; r < 26; r++) begin
            i_cyc = tbl[r].ic; i_stb = tbl[r].ic; i_addr = tbl[r].ia;
            d_cyc = tbl[r].dc; d_stb = tbl[r].dc; d_we = tbl[r].dwe;
            d_addr = tbl[r].da; d_sel = tbl[r].ds; d_wdata = {8{16'hBEEF}};
            m_resp = tbl[r].rs; m_retry = tbl[r].rt;
            #3;
            chk($sformatf("row%0d_m_cyc", r), 128'(m_cyc), 128'(tbl[r].ec));
            chk($sformatf("row%0d_m_stb", r), 128'(m_stb), 128'(tbl[r].es));
            chk($sformatf("row%0d_resps", r), 128'({i_resp, i_retry, d_resp, d_retry}), 128'(tbl[r].er));
            if (tbl[r].es) begin
                chk($sformatf("row%0d_m_we", r), 128'(m_we), 128'(tbl[r].ew));
                chk($sformatf("row%0d_m_addr", r), 128'(m_addr), 128'(tbl[r].ea));
                chk($sformatf("row%0d_m_sel", r), 128'(m_sel), 128'(tbl[r].esl));
            end
            if (tbl[r].er[3]) chk($sformatf("row%0d_i_rdata", r), i_rdata, rd_pat);
            if (tbl[r].er[1]) chk($sformatf("row%0d_d_rdata", r), d_rdata, rd_pat);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Starvation: four D grants, then I, twice over.
        run_starve(10, 16'b0000_0001_1110_1111);

        // Build up starvation count to 3, then reset in the middle of a D transfer.
        run_starve(3, 16'b0000_0000_0000_0111);
        d_cyc = 1; d_stb = 1; d_we = 1; d_addr = 16'h0700; d_sel = 16'h0F0F;
        w = 0;
        while (!m_stb && w < 10) begin
            next_cycle();
            w++;
        end
        chk("rst_mid_granted", 128'(m_stb), 128'(1));
        m_resp = 1;
        #1;
        rst_n = 0;
        #1;
        chk("rst_mid_m_cyc", 128'(m_cyc), 128'(0));
        chk("rst_mid_m_stb", 128'(m_stb), 128'(0));
        chk("rst_mid_resp", 128'({i_resp, d_resp}), 128'(0));
        m_resp = 0; m_retry = 1;
        #1;
        chk("rst_mid_retry", 128'({i_retry, d_retry}), 128'(0));
        next_cycle();
        idle_inputs();
        rst_n = 1;
        next_cycle();
        run_starve(5, 16'b0000_0000_0000_1111);

        // Randomized phase against a transaction-level model.
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        busy = 0; bo = 0; own_d = 0; d_streak = 0;
        cap_we = 0; cap_addr = '0; cap_sel = '0; cap_wdata = '0;
        i_act = 0; d_act = 0;
        for (int c = 0; c < 3000; c++) begin
            logic exp_stb, own_cyc, live, e_ir, e_irt, e_dr, e_drt, ip, dp;
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1; i_addr = 16'($urandom);
            end else if (i_act && $urandom_range(0, 49) == 0) begin
                i_act = 0;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_addr = 16'($urandom); d_we = 1'($urandom);
                d_sel = 16'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (d_act && $urandom_range(0, 49) == 0) begin
                d_act = 0;
            end
            i_cyc = i_act; i_stb = i_act;
            d_cyc = d_act; d_stb = d_act;
            exp_stb = busy && !bo;
            m_resp = 0; m_retry = 0;
            if (exp_stb) begin
                case ($urandom_range(0, 3))
                    0: m_resp = 1;
                    1: m_retry = 1;
                    2: begin m_resp = 1; m_retry = 1; end
                    default: ;
                endcase
            end
            m_rdata = {$urandom, $urandom, $urandom, $urandom};
            #3;
            own_cyc = own_d ? d_cyc : i_cyc;
            live  = exp_stb && own_cyc;
            e_ir  = live && !own_d && m_resp;
            e_irt = live && !own_d && m_retry && !m_resp;
            e_dr  = live && own_d && m_resp;
            e_drt = live && own_d && m_retry && !m_resp;
            chk("rnd_m_cyc", 128'(m_cyc), 128'(busy));
            chk("rnd_m_stb", 128'(m_stb), 128'(exp_stb));
            chk("rnd_i_hs", 128'({i_resp, i_retry}), 128'({e_ir, e_irt}));
            chk("rnd_d_hs", 128'({d_resp, d_retry}), 128'({e_dr, e_drt}));
            chk("rnd_rdata", {i_rdata ^ d_rdata}, 128'(0));
            if (e_ir) chk("rnd_i_rdata", i_rdata, m_rdata);
            if (e_dr) chk("rnd_d_rdata", d_rdata, m_rdata);
            if (exp_stb) begin
                chk("rnd_m_addr", 128'(m_addr), 128'(cap_addr));
                chk("rnd_m_we", 128'(m_we), 128'(cap_we));
                chk("rnd_m_sel", 128'(m_sel), 128'(cap_sel));
                chk("rnd_m_wdata", m_wdata, cap_wdata);
            end
            if (!busy) begin
                ip = i_cyc && i_stb;
                dp = d_cyc && d_stb;
                if (dp && (!ip || d_streak < 4)) begin
                    busy = 1; own_d = 1;
                    cap_addr = d_addr; cap_we = d_we; cap_sel = d_sel; cap_wdata = d_wdata;
                    if (ip && d_streak < 4) d_streak++;
                end else if (ip) begin
                    busy = 1; own_d = 0;
                    cap_addr = i_addr; cap_we = 0; cap_sel = 16'hFFFF; cap_wdata = '0;
                    d_streak = 0;
                end
            end else if (!own_cyc) begin
                busy = 0; bo = 0;
            end else if (bo) begin
                bo = 0;
            end else if (m_resp) begin
                busy = 0;
            end else if (m_retry) begin
                bo = 1;
            end
            if (e_ir) i_act = 0;
            if (e_dr) d_act = 0;
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
